seq_gen: RTL and testbench



---
 rtl/seq_pkg.sv | 12 +
 rtl/seq_shift.sv | 30 +++
 rtl/seq_gen.sv | 145 ++++++++++++++
 tb/tb_seq_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the seq detector and its serial pattern generator.
package seq_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_SEND = 1'b1;

  localparam int unsigned SEQ_WIDTH = 9;

  // Canonical detector target, sent MSB-first.
  localparam logic [8:0] SEQ_PAT = 9'b011100101;

endpackage

// File: rtl/seq_shift.sv
// Load/shift-left register with clear; exposes its MSB as the next serial bit.
module seq_shift #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  output logic             msb
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (clr) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_val;
    end else if (shift_en) begin
      data_q <= {data_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = data_q[WIDTH-1];

endmodule

// File: rtl/seq_gen.sv
// Serial bit-pattern generator: parallel pattern in, MSB-first registered bit stream out.
// Define SEQ_GEN_LOOP_EN to add the `loop` input for seamless pattern repetition.
module seq_gen
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WIDTH,
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic             abort,
`ifdef SEQ_GEN_LOOP_EN
  input  logic             loop,
`endif
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    StIdle = ST_IDLE,
    StSend = ST_SEND
  } state_e;

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(WIDTH);

  state_e           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic             out_q, valid_q, done_q;

  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] aligned;
  logic             accept, last, reload;
  logic [WIDTH-1:0] reload_pat;
  logic [LEN_W-1:0] reload_len;
  logic             sh_msb, sh_clr, sh_load, sh_shift;
  logic [WIDTH-1:0] sh_val;

  assign eff_len = (length > MaxLen) ? MaxLen : length;
  assign aligned = pattern << (MaxLen - eff_len);

  assign accept = (state_q == StIdle) && start_valid && !abort;
  assign last   = (state_q == StSend) && !abort && (cnt_q == LEN_W'(1));

`ifdef SEQ_GEN_LOOP_EN
  logic [WIDTH-1:0] pat_save_q;
  logic [LEN_W-1:0] len_save_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_save_q <= '0;
      len_save_q <= '0;
    end else if (accept && eff_len != '0) begin
      pat_save_q <= aligned;
      len_save_q <= eff_len;
    end
  end

  assign reload     = last && loop;
  assign reload_pat = pat_save_q;
  assign reload_len = len_save_q;
`else
  assign reload     = 1'b0;
  assign reload_pat = '0;
  assign reload_len = '0;
`endif

  // The first bit goes straight to out_q, so the shifter holds only the remainder.
  assign sh_load  = (accept && eff_len != '0) || reload;
  assign sh_val   = accept ? {aligned[WIDTH-2:0], 1'b0} : {reload_pat[WIDTH-2:0], 1'b0};
  assign sh_shift = (state_q == StSend) && !abort && (cnt_q > LEN_W'(1));
  assign sh_clr   = (state_q == StSend) && (abort || (last && !reload));

  seq_shift #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .clr     (sh_clr),
    .load    (sh_load),
    .load_val(sh_val),
    .shift_en(sh_shift),
    .msb     (sh_msb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (eff_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= StSend;
              cnt_q   <= eff_len;
              out_q   <= aligned[WIDTH-1];
              valid_q <= 1'b1;
            end
          end
        end
        StSend: begin
          if (abort) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
          end else if (last) begin
            if (reload) begin
              cnt_q <= reload_len;
              out_q <= reload_pat[WIDTH-1];
            end else begin
              state_q <= StIdle;
              cnt_q   <= '0;
              out_q   <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - LEN_W'(1);
            out_q <= sh_msb;
          end
        end
      endcase
    end
  end

  assign out         = out_q;
  assign out_valid   = valid_q;
  assign done        = done_q;
  assign busy        = (state_q == StSend);
  assign start_ready = (state_q == StIdle);

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: a stream model queues expected bits/done, a monitor checks them.
module tb_seq_gen;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid, start_ready, abort;
  logic [8:0] pattern;
  logic [3:0] length;
  logic       out, out_valid, busy, done;
`ifdef SEQ_GEN_LOOP_EN
  logic       loop;
`endif

  int checks = 0;
  int errors = 0;

  // Expected events: {1'b0, bit} for a serial bit, 2'b10 for a done pulse.
  logic [1:0] exp_q[$];
  logic [1:0] mon_e;

  always #5 clk = ~clk;

  seq_gen #(
    .WIDTH(9),
    .LEN_W(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .pattern    (pattern),
    .length     (length),
    .abort      (abort),
`ifdef SEQ_GEN_LOOP_EN
    .loop       (loop),
`endif
    .out        (out),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (out_valid !== 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bit actual=%0b required=none at %0t", out, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_bit", 32'({1'b0, out}), 32'(mon_e));
        end
      end else begin
        check("idle_line", 32'(out), 0);
      end
      if (done !== 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=%0b required=none at %0t", done, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_pulse", 32'(mon_e), 32'(2'b10));
        end
      end
    end
  end

  // Reference: a transfer of effective length L emits pattern[L-1] down to pattern[0], then done.
  task automatic push_stream(input logic [8:0] pat, input int l, input int nbits,
                             input bit with_done);
    for (int i = 0; i < nbits; i++) exp_q.push_back({1'b0, pat[l-1-i]});
    if (with_done) exp_q.push_back(2'b10);
  endtask

  task automatic send(input logic [8:0] pat, input logic [3:0] len, input int abort_at);
    int l;
    int wait_cnt;
    l = (len > 9) ? 9 : int'(len);
    check("ready_before_start", 32'(start_ready), 1);
    if (abort_at >= 0) push_stream(pat, l, abort_at + 1, 1'b0);
    else push_stream(pat, l, l, 1'b1);
    pattern     = pat;
    length      = len;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    pattern     = 9'($urandom);
    length      = 4'($urandom);
    if (abort_at >= 0) begin
      repeat (abort_at) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", 32'(busy), 0);
      check("abort_ready", 32'(start_ready), 1);
    end else begin
      wait_cnt = 0;
      while (start_ready !== 1'b1 && wait_cnt < 40) begin
        tick();
        wait_cnt++;
      end
      check("ready_latency", wait_cnt, l);
    end
  endtask

  task automatic idle_abort_start();
    pattern     = 9'($urandom);
    length      = 4'($urandom);
    start_valid = 1'b1;
    abort       = 1'b1;
    tick();
    start_valid = 1'b0;
    abort       = 1'b0;
    check("abort_start_busy", 32'(busy), 0);
    check("abort_start_ready", 32'(start_ready), 1);
    tick();
  endtask

  initial begin
    int r, l, ab;
    logic [8:0] p;
    logic [3:0] n;
    rst         = 1'b0;
    start_valid = 1'b0;
    abort       = 1'b0;
    pattern     = '0;
    length      = '0;
`ifdef SEQ_GEN_LOOP_EN
    loop        = 1'b0;
`endif
    #1;
    check("rst_out", 32'(out), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ready", 32'(start_ready), 1);
    #13 rst = 1'b1;
    tick();

    send(SEQ_PAT, 4'd9, -1);
    send(9'b000000101, 4'd3, -1);
    send(9'b110100111, 4'd15, -1);
    send(9'b101010101, 4'd0, -1);
    send(SEQ_PAT, 4'd9, 4);
    tick();
    idle_abort_start();

    // Reset while bit 4 of 9 is on the line.
    push_stream(SEQ_PAT, 9, 4, 1'b0);
    pattern     = SEQ_PAT;
    length      = 4'd9;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b0;
    #1;
    check("midrst_out", 32'(out), 0);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ready", 32'(start_ready), 1);
    #10 rst = 1'b1;
    tick();
    repeat (5) tick();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_ready", 32'(start_ready), 1);

`ifdef SEQ_GEN_LOOP_EN
    // Four passes of 101, loop dropped during the fourth.
    for (int k = 0; k < 4; k++) push_stream(9'b101, 3, 3, 1'b0);
    exp_q.push_back(2'b10);
    loop        = 1'b1;
    pattern     = 9'b101;
    length      = 4'd3;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    repeat (9) tick();
    loop = 1'b0;
    l = 0;
    while (start_ready !== 1'b1 && l < 40) begin
      tick();
      l++;
    end
    check("loop_tail_latency", l, 3);
`endif

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 5);
      if (r == 0) begin
        idle_abort_start();
      end else begin
        p  = 9'($urandom);
        n  = 4'($urandom_range(0, 15));
        l  = (n > 9) ? 9 : int'(n);
        ab = -1;
        if (l > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(0, l - 1);
        send(p, n, ab);
      end
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
